// File: rtl/strobe_period_meter.sv
// strobe_period_meter
//   Measures the number of Clock cycles between consecutive single-cycle
//   strobes on Strobe_i. Each completed interval is reported on Period_o
//   together with a one-cycle Valid_o pulse. If no strobe arrives within
//   MAX_TICKS cycles, Timeout_o pulses for one cycle and the meter re-arms.
//
//   Optional feature (macro STROBE_PERIOD_METER_MINMAX_EN): adds Min_o/Max_o,
//   which track the smallest/largest reported period since the last
//   IDLE->ARMED transition.
//
// Ports:
//   Clock     in   system clock, rising edge
//   Reset     in   asynchronous active-low reset
//   Enable_i  in   measurement enable; low forces IDLE
//   Strobe_i  in   strobe input, one event per high cycle
//   Period_o  out  last measured interval (holds between updates)
//   Valid_o   out  one-cycle pulse when Period_o updates
//   Timeout_o out  one-cycle pulse when MAX_TICKS is exceeded
//   Min_o     out  (optional) smallest period since last clear
//   Max_o     out  (optional) largest period since last clear
module strobe_period_meter #(
  parameter  int MAX_TICKS = 1000,
  localparam int WIDTH     = $clog2(MAX_TICKS + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable_i,
  input  logic             Strobe_i,
  output logic [WIDTH-1:0] Period_o,
  output logic             Valid_o,
`ifdef STROBE_PERIOD_METER_MINMAX_EN
  output logic [WIDTH-1:0] Min_o,
  output logic [WIDTH-1:0] Max_o,
`endif
  output logic             Timeout_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    MEASURING = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MAX_TICKS);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
`ifdef STROBE_PERIOD_METER_MINMAX_EN
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
`ifdef STROBE_PERIOD_METER_MINMAX_EN
    min_d     = min_q;
    max_d     = max_q;
`endif
    if (!Enable_i) begin
      // Disable wins over any strobe sampled on the same edge.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARMED;
          cnt_d   = '0;
`ifdef STROBE_PERIOD_METER_MINMAX_EN
          min_d   = ALL_ONES;
          max_d   = '0;
`endif
        end
        ARMED: begin
          // First strobe only starts the interval; nothing is reported.
          if (Strobe_i) begin
            cnt_d   = CNT_ONE;
            state_d = MEASURING;
          end
        end
        MEASURING: begin
          // At the edge of a strobe cnt_q equals cycles since the previous
          // strobe, so a strobe at cnt_q == MAX_TICKS is still a valid
          // interval and takes priority over the timeout.
          if (Strobe_i) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
`ifdef STROBE_PERIOD_METER_MINMAX_EN
            if (cnt_q < min_q) min_d = cnt_q;
            if (cnt_q > max_q) max_d = cnt_q;
`endif
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ARMED;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef STROBE_PERIOD_METER_MINMAX_EN
      min_q     <= ALL_ONES;
      max_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
`ifdef STROBE_PERIOD_METER_MINMAX_EN
      min_q     <= min_d;
      max_q     <= max_d;
`endif
    end
  end

  assign Period_o  = period_q;
  assign Valid_o   = valid_q;
  assign Timeout_o = timeout_q;
`ifdef STROBE_PERIOD_METER_MINMAX_EN
  assign Min_o     = min_q;
  assign Max_o     = max_q;
`endif

endmodule

// File: tb/tb_strobe_period_meter.sv
// Testbench for strobe_period_meter (MAX_TICKS = 20). The reference model
// works on strobe timestamps: it remembers the cycle index of the last
// accepted strobe and derives periods/timeouts by subtraction.
module tb_strobe_period_meter;

  localparam int MAXT = 20;
  localparam int W    = $clog2(MAXT + 1);
  localparam logic [W-1:0] ALL1 = '1;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         Enable_i = 1'b0;
  logic         Strobe_i = 1'b0;
  logic [W-1:0] Period_o;
  logic         Valid_o;
  logic         Timeout_o;
`ifdef STROBE_PERIOD_METER_MINMAX_EN
  logic [W-1:0] Min_o;
  logic [W-1:0] Max_o;
`endif

  strobe_period_meter #(.MAX_TICKS(MAXT)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Enable_i  (Enable_i),
    .Strobe_i  (Strobe_i),
    .Period_o  (Period_o),
    .Valid_o   (Valid_o),
`ifdef STROBE_PERIOD_METER_MINMAX_EN
    .Min_o     (Min_o),
    .Max_o     (Max_o),
`endif
    .Timeout_o (Timeout_o)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int m_t = 0;          // cycle index
  bit m_active = 0;     // enabled and past the arming edge
  int m_last = -1;      // timestamp of the last accepted strobe, -1 if none
  int m_period = 0;
  bit m_valid = 0;
  bit m_to = 0;
  int m_min = 0;
  int m_max = 0;

  task automatic model_reset();
    m_active = 0; m_last = -1; m_period = 0; m_valid = 0; m_to = 0;
    m_min = int'(ALL1); m_max = 0;
  endtask

  // Drive one cycle, advance the model on the edge, return #1 after it.
  task automatic cyc(input bit en, input bit stb);
    Enable_i = en;
    Strobe_i = stb;
    @(posedge Clock);
    m_t++;
    m_valid = 0;
    m_to = 0;
    if (!en) begin
      m_active = 0; m_last = -1;
    end else if (!m_active) begin
      m_active = 1; m_last = -1; m_min = int'(ALL1); m_max = 0;
    end else if (stb) begin
      if (m_last >= 0) begin
        m_period = m_t - m_last;
        m_valid = 1;
        if (m_period < m_min) m_min = m_period;
        if (m_period > m_max) m_max = m_period;
      end
      m_last = m_t;
    end else if (m_last >= 0 && m_t - m_last == MAXT) begin
      m_to = 1; m_last = -1;
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Enable_i = 1'b0; Strobe_i = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    model_reset();
    n_chk++;
    if ({Valid_o, Timeout_o, Period_o} !== {1'b0, 1'b0, W'(0)})
      $display("FAIL reset: got v=%b t=%b p=%0d, want 0 0 0", Valid_o, Timeout_o, Period_o);
    else n_pass++;
`ifdef STROBE_PERIOD_METER_MINMAX_EN
    n_chk++;
    if ({Min_o, Max_o} !== {ALL1, W'(0)})
      $display("FAIL reset_minmax: got min=%0d max=%0d, want %0d 0", Min_o, Max_o, ALL1);
    else n_pass++;
`endif
    Reset = 1'b1;
  endtask

  task automatic test_periodic(input string tag);
    int nv, nt;
    nv = 0; nt = 0;
    cyc(1, 0);
    for (int i = 0; i <= 40; i++) begin
      cyc(1, (i % 10) == 0);
      n_chk++;
      if ({Valid_o, Timeout_o, Period_o} !== {m_valid, m_to, W'(m_period)})
        $display("FAIL %s cyc%0d: got v=%b t=%b p=%0d, want v=%b t=%b p=%0d",
                 tag, i, Valid_o, Timeout_o, Period_o, m_valid, m_to, m_period);
      else n_pass++;
      if (Valid_o === 1'b1) begin
        nv++;
        n_chk++;
        if (Period_o !== W'(10)) $display("FAIL %s period: got %0d, want 10", tag, Period_o);
        else n_pass++;
      end
      if (Timeout_o === 1'b1) nt++;
    end
    n_chk++;
    if (nv != 4 || nt != 0)
      $display("FAIL %s counts: got valids=%0d timeouts=%0d, want 4 0", tag, nv, nt);
    else n_pass++;
    cyc(0, 0);
  endtask

  task automatic test_back_to_back();
    int nv;
    nv = 0;
    cyc(1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1);
      n_chk++;
      if ({Valid_o, Timeout_o, Period_o} !== {(i > 0), 1'b0, W'(1)} && i > 0)
        $display("FAIL b2b cyc%0d: got v=%b t=%b p=%0d, want v=1 t=0 p=1",
                 i, Valid_o, Timeout_o, Period_o);
      else if (i == 0 && Valid_o !== 1'b0)
        $display("FAIL b2b arm: got v=%b, want v=0", Valid_o);
      else n_pass++;
      if (Valid_o === 1'b1) nv++;
    end
    n_chk++;
    if (nv != 3) $display("FAIL b2b count: got %0d, want 3", nv);
    else n_pass++;
    cyc(0, 0);
  endtask

  task automatic test_boundary();
    int nv, nt;
    cyc(1, 0);
    cyc(1, 1);
    repeat (19) cyc(1, 0);
    cyc(1, 1);
    n_chk++;
    if ({Valid_o, Timeout_o, Period_o} !== {1'b1, 1'b0, W'(20)})
      $display("FAIL gap20: got v=%b t=%b p=%0d, want v=1 t=0 p=20", Valid_o, Timeout_o, Period_o);
    else n_pass++;
    nv = 0; nt = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1, 0);
      if (Valid_o === 1'b1) nv++;
      if (Timeout_o === 1'b1) nt++;
      if (i == 20) begin
        n_chk++;
        if (Timeout_o !== 1'b1) $display("FAIL gap21_to: got t=%b, want t=1", Timeout_o);
        else n_pass++;
      end
    end
    n_chk++;
    if (nv != 0 || nt != 1)
      $display("FAIL gap21_counts: got valids=%0d timeouts=%0d, want 0 1", nv, nt);
    else n_pass++;
    cyc(1, 1);
    n_chk++;
    if ({Valid_o, Timeout_o, Period_o} !== {1'b0, 1'b0, W'(20)})
      $display("FAIL rearm: got v=%b t=%b p=%0d, want v=0 t=0 p=20", Valid_o, Timeout_o, Period_o);
    else n_pass++;
    repeat (9) cyc(1, 0);
    cyc(1, 1);
    n_chk++;
    if ({Valid_o, Period_o} !== {1'b1, W'(10)})
      $display("FAIL after_rearm: got v=%b p=%0d, want v=1 p=10", Valid_o, Period_o);
    else n_pass++;
    cyc(0, 0);
  endtask

  task automatic test_enable();
    int nv;
    cyc(1, 0);
    cyc(1, 1);
    repeat (9) cyc(1, 0);
    cyc(1, 1);
    n_chk++;
    if ({Valid_o, Period_o} !== {1'b1, W'(10)})
      $display("FAIL en_setup: got v=%b p=%0d, want v=1 p=10", Valid_o, Period_o);
    else n_pass++;
    repeat (3) cyc(1, 0);
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, (i % 2) == 0);
      if (Valid_o === 1'b1 || Timeout_o === 1'b1) nv++;
      n_chk++;
      if (Period_o !== W'(10)) $display("FAIL en_hold cyc%0d: got p=%0d, want 10", i, Period_o);
      else n_pass++;
    end
    cyc(1, 0);
    cyc(1, 1);
    if (Valid_o === 1'b1) nv++;
    repeat (6) begin
      cyc(1, 0);
      if (Valid_o === 1'b1) nv++;
    end
    n_chk++;
    if (nv != 0) $display("FAIL en_quiet: got %0d pulses, want 0", nv);
    else n_pass++;
    cyc(1, 1);
    n_chk++;
    if ({Valid_o, Timeout_o, Period_o} !== {1'b1, 1'b0, W'(7)})
      $display("FAIL en_resume: got v=%b t=%b p=%0d, want v=1 t=0 p=7", Valid_o, Timeout_o, Period_o);
    else n_pass++;
    cyc(0, 0);
  endtask

  task automatic test_async_reset();
    cyc(1, 0);
    cyc(1, 1);
    repeat (5) cyc(1, 0);
    cyc(1, 1);
    #3;
    Reset = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if ({Valid_o, Timeout_o, Period_o} !== {1'b0, 1'b0, W'(0)})
      $display("FAIL async_reset: got v=%b t=%b p=%0d, want 0 0 0", Valid_o, Timeout_o, Period_o);
    else n_pass++;
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    test_periodic("post_reset");
  endtask

`ifdef STROBE_PERIOD_METER_MINMAX_EN
  task automatic test_minmax();
    int gaps [3] = '{7, 12, 9};
    cyc(0, 0);
    cyc(1, 0);
    cyc(1, 1);
    foreach (gaps[k]) begin
      repeat (gaps[k] - 1) cyc(1, 0);
      cyc(1, 1);
    end
    n_chk++;
    if ({Min_o, Max_o} !== {W'(7), W'(12)})
      $display("FAIL minmax: got min=%0d max=%0d, want 7 12", Min_o, Max_o);
    else n_pass++;
    cyc(0, 0);
    cyc(1, 0);
    n_chk++;
    if ({Min_o, Max_o} !== {ALL1, W'(0)})
      $display("FAIL minmax_clear: got min=%0d max=%0d, want %0d 0", Min_o, Max_o, ALL1);
    else n_pass++;
    cyc(0, 0);
  endtask
`endif

  task automatic test_random();
    int p;
    p = 20;
    for (int i = 0; i < 800; i++) begin
      if (i % 64 == 0) p = $urandom_range(2, 60);
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 99) < p);
      n_chk++;
      if ({Valid_o, Timeout_o, Period_o} !== {m_valid, m_to, W'(m_period)})
        $display("FAIL random cyc%0d: got v=%b t=%b p=%0d, want v=%b t=%b p=%0d",
                 i, Valid_o, Timeout_o, Period_o, m_valid, m_to, m_period);
      else n_pass++;
`ifdef STROBE_PERIOD_METER_MINMAX_EN
      n_chk++;
      if ({Min_o, Max_o} !== {W'(m_min), W'(m_max)})
        $display("FAIL random_minmax cyc%0d: got min=%0d max=%0d, want %0d %0d",
                 i, Min_o, Max_o, m_min, m_max);
      else n_pass++;
`endif
    end
    cyc(0, 0);
  endtask

  initial begin
    test_reset();
    test_periodic("periodic");
    test_back_to_back();
    test_boundary();
    test_enable();
    test_async_reset();
`ifdef STROBE_PERIOD_METER_MINMAX_EN
    test_minmax();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
